// File: rtl/data_mem_port_if.sv
// Memory-stage request/response bundle between the pipelined core (master)
// and the data-memory responder (slave).
interface data_mem_port_if;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [2:0]  funct3M;
  logic [31:0] ReadData;
  logic        stall;
  logic        acc_err;

  modport master (
    output MemWriteM, MemReadM, Mem_WrAddr, Mem_WrData, funct3M,
    input  ReadData, stall, acc_err
  );

  modport slave (
    input  MemWriteM, MemReadM, Mem_WrAddr, Mem_WrData, funct3M,
    output ReadData, stall, acc_err
  );
endinterface

// File: rtl/data_mem_port.sv
// Byte-addressable data memory for the RISC-V core: masked B/H/W stores,
// extended loads, and word-crossing accesses split over two beats.
module data_mem_port #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_port_if.slave  bus
);
  typedef enum logic {IDLE, SPLIT} state_t;

  state_t      r_state;
  logic [31:0] r_addr, r_data, r_lo, r_read_data;
  logic [2:0]  r_funct3;
  logic        r_is_store, r_acc_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic             w_split, w_req, w_legal, w_go, w_err, w_cross, w_stall;
  logic             w_is_store, w_we, w_ld_done;
  logic [31:0]      w_addr, w_wdata, w_rd_word, w_ld_raw, w_ld_data, w_wr_word;
  logic [2:0]       w_f3;
  logic [1:0]       w_off;
  logic [IDX_W-1:0] w_idx, w_mem_idx;
  logic [3:0]       w_size_mask, w_wr_mask;
  logic [7:0]       w_mask8;
  logic [63:0]      w_data64, w_rd64;
  logic [31:0]      w_unused_addr;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'b0, raw[7:0]};
      3'b101:  return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // In SPLIT the live inputs are ignored; the latched request drives the datapath.
  assign w_split    = (r_state == SPLIT);
  assign w_addr     = w_split ? r_addr     : bus.Mem_WrAddr;
  assign w_wdata    = w_split ? r_data     : bus.Mem_WrData;
  assign w_f3       = w_split ? r_funct3   : bus.funct3M;
  assign w_is_store = w_split ? r_is_store : bus.MemWriteM;
  assign w_off      = w_addr[1:0];
  assign w_idx      = w_addr[IDX_W+1:2];
  assign w_unused_addr = w_addr;

  always_comb begin
    w_legal = 1'b0;
    if (bus.MemWriteM) w_legal = bus.funct3M inside {3'b000, 3'b001, 3'b010};
    else               w_legal = bus.funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  assign w_req   = bus.MemWriteM | bus.MemReadM;
  assign w_go    = !w_split && w_req && w_legal;
  assign w_err   = !w_split && w_req && (!w_legal || (bus.MemWriteM && bus.MemReadM));
  assign w_cross = ((w_f3[1:0] == 2'b01) && (w_off == 2'b11)) ||
                   ((w_f3[1:0] == 2'b10) && (w_off != 2'b00));
  assign w_stall = w_go && w_cross;

  always_comb begin
    w_size_mask = 4'b1111;
    case (w_f3[1:0])
      2'b00:   w_size_mask = 4'b0001;
      2'b01:   w_size_mask = 4'b0011;
      default: w_size_mask = 4'b1111;
    endcase
  end

  // Lanes and data for both beats as one 8-byte window starting at word idx.
  assign w_mask8   = {4'b0, w_size_mask} << w_off;
  assign w_data64  = {32'b0, w_wdata} << {w_off, 3'b000};
  assign w_mem_idx = w_split ? w_idx + IDX_W'(1) : w_idx;
  assign w_wr_mask = w_split ? w_mask8[7:4]   : w_mask8[3:0];
  assign w_wr_word = w_split ? w_data64[63:32] : w_data64[31:0];
  assign w_we      = w_split ? r_is_store : (w_go && w_is_store);

  assign w_rd_word = mem[w_mem_idx];
  assign w_rd64    = w_split ? {w_rd_word, r_lo} : {32'b0, w_rd_word};
  assign w_ld_raw  = 32'(w_rd64 >> {w_off, 3'b000});
  assign w_ld_data = extend(w_ld_raw, w_f3);
  assign w_ld_done = w_split ? !r_is_store : (w_go && !w_is_store && !w_cross);

  // NOTE: the storage array has no reset branch; clearing it would forbid RAM inference.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_mask[b]) mem[w_mem_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_funct3    <= '0;
      r_is_store  <= 1'b0;
      r_lo        <= '0;
      r_read_data <= '0;
      r_acc_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stall) begin
            r_addr     <= bus.Mem_WrAddr;
            r_data     <= bus.Mem_WrData;
            r_funct3   <= bus.funct3M;
            r_is_store <= bus.MemWriteM;
            r_lo       <= w_rd_word;
            r_state    <= SPLIT;
          end
        end
        SPLIT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_ld_done) r_read_data <= w_ld_data;
      if (w_err)     r_acc_err   <= 1'b1;
    end
  end

  assign bus.ReadData = r_read_data;
  assign bus.stall    = w_stall;
  assign bus.acc_err  = r_acc_err;
endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: aligned, sub-word, split, wrap, error
// and reset-during-split cases with hand-computed expectations.
module tb_data_mem_port;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   st;

  data_mem_port_if bus();

  data_mem_port #(.DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request, holds it while stall is high, returns the stall cycle count.
  task automatic req(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f3, output int n);
    n = 0;
    @(negedge clk);
    bus.MemWriteM  = we;
    bus.MemReadM   = re;
    bus.Mem_WrAddr = a;
    bus.Mem_WrData = d;
    bus.funct3M    = f3;
    #1;
    while (bus.stall && n < 4) begin
      n++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.MemWriteM = 1'b0;
    bus.MemReadM  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, input string tag,
                      input logic [31:0] exp, input int exp_stall);
    int n;
    req(1'b0, 1'b1, a, 32'h0, f3, n);
    check({tag, "_data"}, bus.ReadData, exp);
    check({tag, "_stall"}, 32'(n), 32'(exp_stall));
  endtask

  initial begin
    bus.MemWriteM  = 1'b0;
    bus.MemReadM   = 1'b0;
    bus.Mem_WrAddr = '0;
    bus.Mem_WrData = '0;
    bus.funct3M    = '0;
    #12;
    check("rst_rdata", bus.ReadData, 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_err", 32'(bus.acc_err), 32'h0);
    reset = 1'b1;

    // Aligned word store then load.
    req(1'b1, 1'b0, 32'h100, 32'h12345678, 3'b010, st);
    check("sw100_stall", 32'(st), 32'h0);
    load(32'h100, 3'b010, "lw100", 32'h12345678, 0);

    // Byte store into a cleared word and extended loads.
    req(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, st);
    req(1'b1, 1'b0, 32'h106, 32'h000000AB, 3'b000, st);
    load(32'h106, 3'b000, "lb106",  32'hFFFFFFAB, 0);
    load(32'h106, 3'b100, "lbu106", 32'h000000AB, 0);
    load(32'h104, 3'b010, "lw104",  32'h00AB0000, 0);
    load(32'h106, 3'b001, "lh106",  32'h000000AB, 0);

    // Split word store/load across words 0 and 1.
    req(1'b1, 1'b0, 32'h000, 32'h0, 3'b010, st);
    req(1'b1, 1'b0, 32'h004, 32'h0, 3'b010, st);
    req(1'b1, 1'b0, 32'h003, 32'hDDCCBBAA, 3'b010, st);
    check("sw003_stall", 32'(st), 32'h1);
    load(32'h000, 3'b010, "lw000", 32'hAA000000, 0);
    load(32'h004, 3'b010, "lw004", 32'h00DDCCBB, 0);
    load(32'h003, 3'b010, "lw003", 32'hDDCCBBAA, 1);

    // Halfword crossing the top word wraps to word 0.
    req(1'b1, 1'b0, 32'hFFC, 32'h80000000, 3'b010, st);
    req(1'b1, 1'b0, 32'h000, 32'h00000001, 3'b010, st);
    load(32'hFFF, 3'b001, "lhfff", 32'h00000180, 1);
    req(1'b1, 1'b0, 32'hFFF, 32'h0000BEEF, 3'b001, st);
    check("shfff_stall", 32'(st), 32'h1);
    load(32'hFFC, 3'b010, "lwffc", 32'hEF000000, 0);
    load(32'h000, 3'b010, "lw000w", 32'h000000BE, 0);
    load(32'hFFE, 3'b001, "lhffe", 32'hFFFFEF00, 0);
    load(32'hFFE, 3'b101, "lhuffe", 32'h0000EF00, 0);
    load(32'h1100, 3'b010, "lwalias", 32'h12345678, 0);

    // Illegal funct3 load: no data update, sticky error.
    check("err_pre", 32'(bus.acc_err), 32'h0);
    req(1'b0, 1'b1, 32'h100, 32'h0, 3'b011, st);
    check("err_rdata", bus.ReadData, 32'h12345678);
    check("err_set", 32'(bus.acc_err), 32'h1);
    load(32'h004, 3'b010, "lw004b", 32'h00DDCCBB, 0);
    check("err_sticky", 32'(bus.acc_err), 32'h1);

    // Reset asserted during the second beat of a split store.
    req(1'b1, 1'b0, 32'h200, 32'h11111111, 3'b010, st);
    req(1'b1, 1'b0, 32'h204, 32'h22222222, 3'b010, st);
    @(negedge clk);
    bus.MemWriteM  = 1'b1;
    bus.MemReadM   = 1'b0;
    bus.Mem_WrAddr = 32'h201;
    bus.Mem_WrData = 32'hDDCCBBAA;
    bus.funct3M    = 3'b010;
    #1;
    check("rs_stall_hi", 32'(bus.stall), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.MemWriteM = 1'b0;
    #1;
    check("rs_stall", 32'(bus.stall), 32'h0);
    check("rs_rdata", bus.ReadData, 32'h0);
    check("rs_err", 32'(bus.acc_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    load(32'h200, 3'b010, "rs_lw200", 32'hCCBBAA11, 0);
    load(32'h204, 3'b010, "rs_lw204", 32'h22222222, 0);

    // Store and load together: store wins, error flagged.
    req(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 3'b010, st);
    check("both_err", 32'(bus.acc_err), 32'h1);
    load(32'h300, 3'b010, "both_lw", 32'hCAFEF00D, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
